usb_endpoint_protocol_ctrl: RTL and testbench
=============================================

# usb_endpoint_protocol_ctrl

Transaction-level controller for the bulk endpoint. It consumes decoded packet events from the USB receiver and drives the USB transmitter, answering OUT and IN tokens with DATA0/DATA1, ACK or NAK. It commits or discards received payload in the endpoint buffer and tracks data toggles for both directions. It enforces a bus-turnaround timeout, and sits between the RX control path, the TX path and the endpoint buffer.

## Interface
- TIMEOUT_CYCLES, 1024: clk cycles allowed while waiting for DATA after OUT, or for ACK after IN data
- clk  in  1  clock
- n_rst  in  1  asynchronous, active-low reset
- rx_done  in  1  one-cycle pulse: packet received without error; rx_pid valid
- rx_error  in  1  one-cycle pulse: packet ended in error
- rx_pid  in  4  decoded PID: OUT=0001, IN=1001, DATA0=0011, DATA1=1011, ACK=0010
- buffer_occupancy  in  7  bytes of committed, unread data in the endpoint buffer
- tx_data_ready  in  1  level: an IN packet is loaded and ready to send
- tx_done  in  1  one-cycle pulse: transmitter finished the current packet
- toggle_reset  in  1  one-cycle pulse: clear both data toggles
- tx_start  out  1  one-cycle pulse: start transmission of tx_packet
- tx_packet  out  2  00 ACK, 01 NAK, 10 DATA0, 11 DATA1; held stable from tx_start until tx_done
- rx_commit  out  1  pulse: accept the staged OUT payload into the buffer
- rx_discard  out  1  pulse: drop the staged OUT payload
- clear_buffer  out  1  pulse: release the IN packet after it is ACKed
- out_received  out  1  pulse: a new OUT packet was committed
- in_acked  out  1  pulse: the host ACKed the IN packet
- transfer_error  out  1  pulse: the transaction was aborted
- busy  out  1  state != IDLE

## Operation
- States: IDLE, OUT_WAIT, COMMIT, DISCARD, HS_START, HS_WAIT, DATA_START, DATA_WAIT, ACK_WAIT, ACKED, ERROR.
- Moore outputs:
  - rx_commit = out_received = COMMIT
  - rx_discard = DISCARD | ERROR
  - tx_start = HS_START | DATA_START
  - clear_buffer = in_acked = ACKED
  - transfer_error = ERROR
- tx_packet is a register, loaded when the next-state decision selects the response.
- IDLE:
  - rx_done with OUT → OUT_WAIT.
  - rx_done with IN and tx_data_ready=1 → DATA_START, tx_packet = {1, in_toggle}.
  - rx_done with IN and tx_data_ready=0 → HS_START, tx_packet = NAK.
  - All other events are ignored.
- OUT_WAIT, on rx_done with DATA0/DATA1:
  - buffer_occupancy != 0 → DISCARD, NAK.
  - else PID toggle == out_toggle → COMMIT, ACK.
  - else (retransmission) → DISCARD, ACK.
- OUT_WAIT, on rx_error, any other PID, or timeout → ERROR.
- COMMIT → HS_START; out_toggle flips on this transition. DISCARD → HS_START.
- HS_START → HS_WAIT. HS_WAIT → IDLE on tx_done.
- DATA_START → DATA_WAIT. DATA_WAIT → ACK_WAIT on tx_done.
- ACK_WAIT:
  - rx_done with ACK → ACKED, and in_toggle flips.
  - rx_error, another PID, or timeout → ERROR; in_toggle and data are kept for retry.
- ACKED → IDLE. ERROR → IDLE.
- Timer: $clog2(TIMEOUT_CYCLES) bits. It clears on entry to OUT_WAIT or ACK_WAIT and increments each cycle in those states. Timeout fires when count == TIMEOUT_CYCLES-1.

## Timing
- Reset: state IDLE, every output 0, tx_packet 00, both toggles 0, timer 0.
- Reset mid-transaction aborts immediately to these values; no pulses are emitted.
- IN token rx_done at cycle N → tx_start at N+1.
- DATA rx_done at N → rx_commit/rx_discard at N+1, tx_start at N+2.
- ACK rx_done at N → clear_buffer/in_acked at N+1, busy low at N+2.
- Timeout: entry to a wait state at cycle E → ERROR at E+TIMEOUT_CYCLES.
- Simultaneous events:
  - rx_error with rx_done: rx_error wins.
  - rx_done on the timeout cycle: rx_done wins.
  - toggle_reset with a toggle flip: reset wins (toggle = 0).
- tx_done outside HS_WAIT/DATA_WAIT and rx_done in HS_*/DATA_* states are ignored.

## Test plan
- OUT, then DATA0 (toggle 0, occupancy 0) → rx_commit and out_received at N+1; tx_start with tx_packet=00 at N+2; tx_done → IDLE; out_toggle = 1.
- Repeat DATA0 with out_toggle=1 → rx_discard, ACK sent, no out_received, toggle remains 1. Then OUT with occupancy=64 → rx_discard, NAK sent.
- IN with tx_data_ready=1 → DATA0 sent, tx_done, host ACK → clear_buffer at +1, in_toggle = 1. Next IN → tx_packet=11.
- IN with tx_data_ready=0 → tx_packet=01 (NAK), no clear_buffer.
- DATA sent, no ACK (TIMEOUT_CYCLES=16) → transfer_error exactly 16 cycles after ACK_WAIT entry; in_toggle unchanged. OUT then rx_error → ERROR with rx_discard.
- toggle_reset coincident with COMMIT → out_toggle = 0. n_rst asserted in DATA_WAIT → all outputs 0 at once.

Source files
------------

// File: rtl/usb_endpoint_protocol_ctrl.sv
// usb_endpoint_protocol_ctrl
//   Transaction-level controller for the bulk endpoint. Answers OUT tokens
//   (DATA stage, then ACK/NAK handshake) and IN tokens (DATA0/DATA1 or NAK,
//   then waits for the host ACK). It also tracks the data toggles for both
//   directions and enforces the bus-turnaround timeout.
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   rx_done_i/rx_error_i  receiver event pulses; rx_pid_i is valid with rx_done_i
//   buffer_occupancy_i    committed, unread bytes in the endpoint buffer
//   tx_data_ready_i       an IN packet is loaded and ready to send
//   tx_done_i             transmitter finished the current packet
//   toggle_reset_i        clear both data toggles
//   tx_start_o/tx_packet_o  start a transmission; packet type 00 ACK, 01 NAK,
//                           10 DATA0, 11 DATA1
//   rx_commit_o/rx_discard_o  accept or drop the staged OUT payload
//   clear_buffer_o        release the IN packet once it has been ACKed
//   out_received_o, in_acked_o, transfer_error_o  status pulses
//   busy_o                a transaction is in progress
module usb_endpoint_protocol_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_done_i,
  input  logic       rx_error_i,
  input  logic [3:0] rx_pid_i,
  input  logic [6:0] buffer_occupancy_i,
  input  logic       tx_data_ready_i,
  input  logic       tx_done_i,
  input  logic       toggle_reset_i,
  output logic       tx_start_o,
  output logic [1:0] tx_packet_o,
  output logic       rx_commit_o,
  output logic       rx_discard_o,
  output logic       clear_buffer_o,
  output logic       out_received_o,
  output logic       in_acked_o,
  output logic       transfer_error_o,
  output logic       busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  localparam logic [1:0] PKT_ACK = 2'b00;
  localparam logic [1:0] PKT_NAK = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OUT_WAIT,
    S_COMMIT,
    S_DISCARD,
    S_HS_START,
    S_HS_WAIT,
    S_DATA_START,
    S_DATA_WAIT,
    S_ACK_WAIT,
    S_ACKED,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    tx_packet_q, tx_packet_d;
  logic          out_tog_q, out_tog_d;
  logic          in_tog_q, in_tog_d;
  logic [TW-1:0] timer_q, timer_d;

  // A receive error always overrides a coincident rx_done.
  logic rx_ok;
  logic is_data;
  logic waiting;
  logic timeout;

  assign rx_ok   = rx_done_i & ~rx_error_i;
  assign is_data = (rx_pid_i == PID_DATA0) || (rx_pid_i == PID_DATA1);
  assign waiting = (state_q == S_OUT_WAIT) || (state_q == S_ACK_WAIT);
  assign timeout = (timer_q == TMAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      tx_packet_q <= 2'b00;
      out_tog_q   <= 1'b0;
      in_tog_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_packet_q <= tx_packet_d;
      out_tog_q   <= out_tog_d;
      in_tog_q    <= in_tog_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_packet_d = tx_packet_q;
    out_tog_d   = out_tog_q;
    in_tog_d    = in_tog_q;
    // Outside the wait states the timer sits at zero, so it reads zero on
    // the first cycle of OUT_WAIT / ACK_WAIT.
    timer_d     = waiting ? (timer_q + TW'(1)) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_ok && rx_pid_i == PID_OUT) begin
          state_d = S_OUT_WAIT;
        end else if (rx_ok && rx_pid_i == PID_IN) begin
          if (tx_data_ready_i) begin
            state_d     = S_DATA_START;
            tx_packet_d = {1'b1, in_tog_q};
          end else begin
            state_d     = S_HS_START;
            tx_packet_d = PKT_NAK;
          end
        end
      end
      S_OUT_WAIT: begin
        if (rx_error_i) begin
          state_d = S_ERROR;
        end else if (rx_done_i) begin
          if (!is_data) begin
            state_d = S_ERROR;
          end else if (buffer_occupancy_i != 7'd0) begin
            state_d     = S_DISCARD;
            tx_packet_d = PKT_NAK;
          end else if (rx_pid_i[3] == out_tog_q) begin
            state_d     = S_COMMIT;
            tx_packet_d = PKT_ACK;
          end else begin
            // Host retransmitted data we already accepted: ACK it again.
            state_d     = S_DISCARD;
            tx_packet_d = PKT_ACK;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_COMMIT: begin
        state_d   = S_HS_START;
        out_tog_d = ~out_tog_q;
      end
      S_DISCARD:    state_d = S_HS_START;
      S_HS_START:   state_d = S_HS_WAIT;
      S_HS_WAIT:    if (tx_done_i) state_d = S_IDLE;
      S_DATA_START: state_d = S_DATA_WAIT;
      S_DATA_WAIT:  if (tx_done_i) state_d = S_ACK_WAIT;
      S_ACK_WAIT: begin
        if (rx_error_i) begin
          state_d = S_ERROR;
        end else if (rx_done_i) begin
          if (rx_pid_i == PID_ACK) begin
            state_d  = S_ACKED;
            in_tog_d = ~in_tog_q;
          end else begin
            state_d = S_ERROR;
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_ACKED: state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An explicit toggle reset overrides any flip made in the same cycle.
    if (toggle_reset_i) begin
      out_tog_d = 1'b0;
      in_tog_d  = 1'b0;
    end
  end

  assign tx_packet_o      = tx_packet_q;
  assign tx_start_o       = (state_q == S_HS_START) || (state_q == S_DATA_START);
  assign rx_commit_o      = (state_q == S_COMMIT);
  assign out_received_o   = (state_q == S_COMMIT);
  assign rx_discard_o     = (state_q == S_DISCARD) || (state_q == S_ERROR);
  assign clear_buffer_o   = (state_q == S_ACKED);
  assign in_acked_o       = (state_q == S_ACKED);
  assign transfer_error_o = (state_q == S_ERROR);
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_endpoint_protocol_ctrl.sv
// Testbench for usb_endpoint_protocol_ctrl: directed transactions with
// literal expectations, followed by randomized event traffic, all checked
// every cycle against a transaction-phase model.
module tb_usb_endpoint_protocol_ctrl;
  localparam int T = 16;

  localparam logic [3:0] P_OUT = 4'b0001;
  localparam logic [3:0] P_IN  = 4'b1001;
  localparam logic [3:0] P_D0  = 4'b0011;
  localparam logic [3:0] P_D1  = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_done = 1'b0, rx_error = 1'b0, tx_data_ready = 1'b0;
  logic       tx_done = 1'b0, toggle_reset = 1'b0;
  logic [3:0] rx_pid = 4'b0000;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       tx_start, rx_commit, rx_discard, clear_buffer;
  logic       out_received, in_acked, transfer_error, busy;
  logic [1:0] tx_packet;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_endpoint_protocol_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst),
    .rx_done_i(rx_done), .rx_error_i(rx_error), .rx_pid_i(rx_pid),
    .buffer_occupancy_i(buffer_occupancy), .tx_data_ready_i(tx_data_ready),
    .tx_done_i(tx_done), .toggle_reset_i(toggle_reset),
    .tx_start_o(tx_start), .tx_packet_o(tx_packet),
    .rx_commit_o(rx_commit), .rx_discard_o(rx_discard),
    .clear_buffer_o(clear_buffer), .out_received_o(out_received),
    .in_acked_o(in_acked), .transfer_error_o(transfer_error), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase of the current transaction; "left" counts down the cycles still
  // allowed in a turnaround wait.
  localparam int M_IDLE = 0, M_OUTW = 1, M_ACCEPT = 2, M_DROP = 3, M_HS_TX = 4,
                 M_HS_BUSY = 5, M_D_TX = 6, M_D_BUSY = 7, M_ACKW = 8,
                 M_GOTACK = 9, M_ABORT = 10;
  int         m_ph, n_ph, m_left, n_left;
  logic       m_ot, n_ot, m_it, n_it;
  logic [1:0] m_pkt, n_pkt;

  always_comb begin
    n_ph = m_ph; n_left = m_left; n_ot = m_ot; n_it = m_it; n_pkt = m_pkt;
    case (m_ph)
      M_IDLE:
        if (rx_done && !rx_error && rx_pid == P_OUT) begin
          n_ph = M_OUTW; n_left = T;
        end else if (rx_done && !rx_error && rx_pid == P_IN) begin
          n_ph  = tx_data_ready ? M_D_TX : M_HS_TX;
          n_pkt = tx_data_ready ? {1'b1, m_it} : 2'b01;
        end
      M_OUTW:
        if (rx_error) n_ph = M_ABORT;
        else if (rx_done) begin
          if (rx_pid != P_D0 && rx_pid != P_D1) n_ph = M_ABORT;
          else if (buffer_occupancy != 0) begin n_ph = M_DROP; n_pkt = 2'b01; end
          else if ((rx_pid == P_D1) == m_ot) begin n_ph = M_ACCEPT; n_pkt = 2'b00; end
          else begin n_ph = M_DROP; n_pkt = 2'b00; end
        end else if (m_left == 1) n_ph = M_ABORT;
        else n_left = m_left - 1;
      M_ACCEPT: begin n_ph = M_HS_TX; n_ot = !m_ot; end
      M_DROP:    n_ph = M_HS_TX;
      M_HS_TX:   n_ph = M_HS_BUSY;
      M_HS_BUSY: if (tx_done) n_ph = M_IDLE;
      M_D_TX:    n_ph = M_D_BUSY;
      M_D_BUSY:  if (tx_done) begin n_ph = M_ACKW; n_left = T; end
      M_ACKW:
        if (rx_error) n_ph = M_ABORT;
        else if (rx_done) begin
          if (rx_pid == P_ACK) begin n_ph = M_GOTACK; n_it = !m_it; end
          else n_ph = M_ABORT;
        end else if (m_left == 1) n_ph = M_ABORT;
        else n_left = m_left - 1;
      default: n_ph = M_IDLE;
    endcase
    if (toggle_reset) begin n_ot = 1'b0; n_it = 1'b0; end
  end

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_ph <= M_IDLE; m_left <= 0; m_ot <= 1'b0; m_it <= 1'b0; m_pkt <= 2'b00;
    end else begin
      m_ph <= n_ph; m_left <= n_left; m_ot <= n_ot; m_it <= n_it; m_pkt <= n_pkt;
    end
  end

  // Every cycle: DUT outputs vs. what the model's phase implies.
  logic [9:0] exp_vec, act_vec;
  always_comb begin
    exp_vec = {m_ph == M_HS_TX || m_ph == M_D_TX, m_pkt,
               m_ph == M_ACCEPT, m_ph == M_DROP || m_ph == M_ABORT,
               m_ph == M_GOTACK, m_ph == M_ACCEPT, m_ph == M_GOTACK,
               m_ph == M_ABORT, m_ph != M_IDLE};
    act_vec = {tx_start, tx_packet, rx_commit, rx_discard, clear_buffer,
               out_received, in_acked, transfer_error, busy};
  end

  always @(negedge clk) chk("model_cmp {start,pkt,commit,discard,clrbuf,outrx,inack,err,busy}",
                            32'(act_vec), 32'(exp_vec));

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rx_done = 1'b0; rx_error = 1'b0; tx_done = 1'b0; toggle_reset = 1'b0;
  endtask

  // OUT token then a DATA packet; returns in the COMMIT/DISCARD/ERROR cycle.
  task automatic out_txn(input logic [3:0] pid, input logic [6:0] occ);
    rx_done = 1'b1; rx_pid = P_OUT; step();
    buffer_occupancy = occ; rx_done = 1'b1; rx_pid = pid; step();
    buffer_occupancy = 7'd0;
  endtask

  // From COMMIT/DISCARD: handshake start, wait, transmitter done.
  task automatic hs_tail();
    step(); step(); tx_done = 1'b1; step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_outputs", 32'(act_vec), 0);
    n_rst = 1'b1;
    step();

    // OUT + DATA0, toggle 0, empty buffer: commit and ACK
    out_txn(P_D0, 7'd0);
    chk("commit_pulse", 32'(rx_commit), 1);
    chk("out_received_pulse", 32'(out_received), 1);
    step();
    chk("ack_tx_start", 32'(tx_start), 1);
    chk("ack_tx_packet", 32'(tx_packet), 32'h0);
    step(); tx_done = 1'b1; step();
    chk("idle_after_hs", 32'(busy), 0);

    // retransmitted DATA0 with out_toggle=1: discard, still ACK
    out_txn(P_D0, 7'd0);
    chk("retx_discard", 32'(rx_discard), 1);
    chk("retx_no_out_received", 32'(out_received), 0);
    step();
    chk("retx_ack_packet", 32'(tx_packet), 32'h0);
    step(); tx_done = 1'b1; step();

    // buffer occupied: discard and NAK
    out_txn(P_D1, 7'd64);
    chk("full_discard", 32'(rx_discard), 1);
    step();
    chk("full_nak_packet", 32'(tx_packet), 32'h1);
    step(); tx_done = 1'b1; step();

    // IN with data ready: DATA0, host ACK
    tx_data_ready = 1'b1; rx_done = 1'b1; rx_pid = P_IN; step();
    chk("in_tx_start", 32'(tx_start), 1);
    chk("in_data0_packet", 32'(tx_packet), 32'h2);
    step(); tx_done = 1'b1; step();
    rx_done = 1'b1; rx_pid = P_ACK; step();
    chk("clear_buffer_pulse", 32'(clear_buffer), 1);
    step();
    chk("busy_low_after_ack", 32'(busy), 0);

    // next IN uses DATA1; host stays silent -> timeout
    rx_done = 1'b1; rx_pid = P_IN; step();
    chk("in_data1_packet", 32'(tx_packet), 32'h3);
    step(); tx_done = 1'b1; step();
    for (int k = 1; k <= T; k++) begin
      step();
      if (k == T - 1) chk("no_early_timeout", 32'(transfer_error), 0);
      if (k == T) chk("timeout_error", 32'(transfer_error), 1);
    end
    step();
    // retry keeps DATA1
    rx_done = 1'b1; rx_pid = P_IN; step();
    chk("retry_keeps_data1", 32'(tx_packet), 32'h3);
    step(); tx_done = 1'b1; step();
    rx_done = 1'b1; rx_pid = P_ACK; step(); step();

    // IN with no data: NAK
    tx_data_ready = 1'b0; rx_done = 1'b1; rx_pid = P_IN; step();
    chk("in_nak_packet", 32'(tx_packet), 32'h1);
    chk("in_nak_no_clear", 32'(clear_buffer), 0);
    step(); tx_done = 1'b1; step();

    // OUT then rx_error
    rx_done = 1'b1; rx_pid = P_OUT; step();
    rx_error = 1'b1; step();
    chk("rx_error_abort", 32'(transfer_error), 1);
    chk("rx_error_discard", 32'(rx_discard), 1);
    step();

    // out_toggle is 1: DATA1 commits and flips it to 0
    out_txn(P_D1, 7'd0);
    hs_tail();
    // DATA0 commits; toggle_reset in the COMMIT cycle keeps the toggle at 0
    out_txn(P_D0, 7'd0);
    toggle_reset = 1'b1;
    hs_tail();
    out_txn(P_D0, 7'd0);
    chk("toggle_reset_wins", 32'(rx_commit), 1);
    hs_tail();

    // reset in DATA_WAIT
    tx_data_ready = 1'b1; rx_done = 1'b1; rx_pid = P_IN; step(); step();
    chk("data_wait_busy", 32'(busy), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({act_vec[9], act_vec[7:0]}), 0);
    chk("async_reset_packet", 32'(tx_packet), 0);
    @(posedge clk); #1 n_rst = 1'b1;

    // randomized event traffic
    for (int i = 0; i < 4000; i++) begin
      rx_done  = ($urandom_range(0, 3) == 0);
      rx_error = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 5))
        0: rx_pid = P_OUT;
        1: rx_pid = P_IN;
        2: rx_pid = P_D0;
        3: rx_pid = P_D1;
        4: rx_pid = P_ACK;
        default: rx_pid = 4'($urandom);
      endcase
      tx_done          = ($urandom_range(0, 3) == 0);
      toggle_reset     = ($urandom_range(0, 49) == 0);
      buffer_occupancy = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      tx_data_ready    = $urandom_range(0, 1) == 1;
      @(posedge clk);
      #1;
    end
    rx_done = 1'b0; rx_error = 1'b0; tx_done = 1'b0; toggle_reset = 1'b0;
    @(posedge clk); @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
